// File: rtl/xprog_loader_pkg.sv
// Shared definitions for the program RAM loader: FSM state encodings,
// error codes and a small state-classification helper.
package xprog_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_WRITE = 2'd2,
        ST_CSUM  = 2'd3
    } state_e;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_CSUM    = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_ABORT   = 2'b11;

    // States in which the loader is consuming stream bytes.
    function automatic logic isStreamState(input state_e s);
        return (s == ST_RECV) || (s == ST_CSUM);
    endfunction

endpackage

// File: rtl/xprog_loader_asm.sv
// Byte-to-word assembler: packs accepted bytes little-endian into a DATA_W word.
// word_o already includes the byte strobed this cycle, so a completed word is usable immediately.
module xprog_loader_asm #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              strobe_i,
    input  logic [7:0]        byte_i,
    output logic [DATA_W-1:0] word_o,
    output logic              word_full_o
);

    localparam int NBYTES = DATA_W / 8;
    localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NBYTES - 1);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] word_q, word_d;

    always_comb begin
        cnt_d  = cnt_q;
        word_d = word_q;
        if (clear_i) begin
            cnt_d  = '0;
            word_d = '0;
        end else if (strobe_i) begin
            word_d[cnt_q*8 +: 8] = byte_i;
            cnt_d = (cnt_q == LAST_BYTE) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            word_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            word_q <= word_d;
        end
    end

    assign word_o      = word_d;
    assign word_full_o = strobe_i && !clear_i && (cnt_q == LAST_BYTE);

endmodule

// File: rtl/xprog_loader.sv
// Boot/reload sequencer: assembles a byte stream into words, writes them to the
// program RAM from a base address, and validates the load with a trailing checksum word.
module xprog_loader
    import xprog_loader_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 32,
    parameter int TIMEOUT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   len,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              dma_sel,
    output logic              dma_we,
    output logic [ADDR_W-1:0] dma_addr,
    output logic [DATA_W-1:0] dma_data,
    output logic              busy,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code
);

    // Timeout fires on the idle cycle that would bring the counter to all-ones.
    localparam logic [TIMEOUT_W-1:0] TO_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W:0]   idx_q, idx_d;
    logic [DATA_W-1:0] sum_q, sum_d;
    logic [TIMEOUT_W-1:0] to_q, to_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [1:0]        code_q, code_d;

    logic              streaming;
    logic              xfer;
    logic              timeout;
    logic              asmClear;
    logic [DATA_W-1:0] asmWord;
    logic              asmFull;

    assign streaming = isStreamState(state_q);
    assign xfer      = byte_valid && streaming;
    assign timeout   = streaming && !xfer && (to_q == TO_LAST);
    assign asmClear  = (state_q == ST_IDLE) && start;

    xprog_loader_asm #(
        .DATA_W (DATA_W)
    ) u_asm (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (asmClear),
        .strobe_i    (xfer),
        .byte_i      (byte_data),
        .word_o      (asmWord),
        .word_full_o (asmFull)
    );

    always_comb begin
        to_d = '0;
        if (streaming && !xfer) begin
            to_d = to_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        len_d   = len_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        addr_d  = addr_q;
        data_d  = data_q;
        done_d  = 1'b0;
        err_d   = err_q;
        code_d  = code_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    base_d  = base_addr;
                    len_d   = len;
                    idx_d   = '0;
                    sum_d   = '0;
                    err_d   = 1'b0;
                    code_d  = ERR_NONE;
                    state_d = (len != '0) ? ST_RECV : ST_CSUM;
                end
            end
            ST_RECV: begin
                if (timeout) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                    code_d  = ERR_TIMEOUT;
                end else if (asmFull) begin
                    // Latch the write beat now so the RAM port stays stable afterwards.
                    addr_d  = base_q + idx_q[ADDR_W-1:0];
                    data_d  = asmWord;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                sum_d   = sum_q + data_q;
                idx_d   = idx_q + 1'b1;
                state_d = (idx_d == len_q) ? ST_CSUM : ST_RECV;
            end
            ST_CSUM: begin
                if (timeout) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                    code_d  = ERR_TIMEOUT;
                end else if (asmFull) begin
                    state_d = ST_IDLE;
                    if (asmWord == sum_q) begin
                        done_d = 1'b1;
                    end else begin
                        err_d  = 1'b1;
                        code_d = ERR_CSUM;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort outranks timeout and completion; a WRITE in flight still drives the RAM this cycle.
        if ((state_q != ST_IDLE) && abort) begin
            state_d = ST_IDLE;
            done_d  = 1'b0;
            err_d   = 1'b1;
            code_d  = ERR_ABORT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            base_q  <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            sum_q   <= '0;
            to_q    <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            to_q    <= to_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            done_q  <= done_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    assign byte_ready = streaming;
    assign dma_sel    = (state_q == ST_WRITE);
    assign dma_we     = (state_q == ST_WRITE);
    assign dma_addr   = addr_q;
    assign dma_data   = data_q;
    assign busy       = (state_q != ST_IDLE);
    assign cpu_hold   = (state_q != ST_IDLE);
    assign done       = done_q;
    assign err        = err_q;
    assign err_code   = code_q;

endmodule

// File: tb/tb_xprog_loader.sv
// Self-checking bench for xprog_loader: table-driven and random loads against a
// word-level reference model, plus hand-written timeout/abort/reset sequences.
module tb_xprog_loader;

    localparam int AW         = 10;
    localparam int DW         = 32;
    localparam int TW         = 8;
    localparam int RAM_WORDS  = 1 << AW;
    localparam int IDLE_LIMIT = (1 << TW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start;
    logic          abort;
    logic [AW-1:0] base_addr;
    logic [AW:0]   len;
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          byte_ready;
    logic          dma_sel;
    logic          dma_we;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_data;
    logic          busy;
    logic          cpu_hold;
    logic          done;
    logic          err;
    logic [1:0]    err_code;

    always #5 clk = ~clk;

    xprog_loader #(
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .TIMEOUT_W (TW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .base_addr  (base_addr),
        .len        (len),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .dma_sel    (dma_sel),
        .dma_we     (dma_we),
        .dma_addr   (dma_addr),
        .dma_data   (dma_data),
        .busy       (busy),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .err        (err),
        .err_code   (err_code)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    typedef struct {
        logic [AW-1:0] base;
        int            n;
        bit            badSum;
        int            maxGap;
        bit            midStart;
    } vec_t;

    wr_t wrLog[$];
    int  doneSeen = 0;
    int  total    = 0;
    int  bad      = 0;

    // RAM write and done-pulse observer, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (dma_we) begin
                wr_t e;
                e.addr = dma_addr;
                e.data = dma_data;
                wrLog.push_back(e);
            end
            if (done) doneSeen++;
        end
    end

    initial begin
        repeat (90000) @(posedge clk);
        $display("[TB] FAIL watchdog: got no finish, expected finish within 90000 cycles");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] wordSum(input logic [DW-1:0] q[$]);
        logic [DW-1:0] s = '0;
        foreach (q[i]) s += q[i];
        return s;
    endfunction

    task automatic pulseStart(input logic [AW-1:0] b, input logic [AW:0] n, input int cycles);
        base_addr = b;
        len       = n;
        start     = 1'b1;
        repeat (cycles) begin @(posedge clk); #1; end
        start = 1'b0;
    endtask

    task automatic sendByte(input logic [7:0] v, input int gap);
        int w = 0;
        repeat (gap) begin @(posedge clk); #1; end
        byte_valid = 1'b1;
        byte_data  = v;
        @(negedge clk);
        while (!byte_ready && w < 64) begin @(negedge clk); w++; end
        if (!byte_ready) checkOutput("handshake.ready", byte_ready, 1);
        @(posedge clk); #1;
        byte_valid = 1'b0;
    endtask

    task automatic waitIdle(input int limit, output int cycles);
        cycles = 0;
        @(negedge clk);
        while (busy && cycles < limit) begin @(negedge clk); cycles++; end
        checkOutput("idle.busy", busy, 0);
        @(posedge clk); #1;
    endtask

    // One complete load; expected writes and result come from the word-level model.
    task automatic applyStimulus(input logic [AW-1:0] b, input int n, input logic [DW-1:0] words[$],
                                 input logic [DW-1:0] csum, input int minGap, input int maxGap,
                                 input bit midStart, input string tag);
        wr_t           expWr[$];
        logic [DW-1:0] sum = '0;
        logic [DW-1:0] w;
        bit            expDone;
        int            doneBefore;
        int            cyc;
        for (int i = 0; i < n; i++) begin
            wr_t e;
            e.addr = AW'((int'(b) + i) % RAM_WORDS);
            e.data = words[i];
            expWr.push_back(e);
            sum += words[i];
        end
        expDone = (csum == sum);
        wrLog.delete();
        doneBefore = doneSeen;
        pulseStart(b, (AW+1)'(n), 1);
        for (int i = 0; i < n; i++) begin
            w = words[i];
            for (int k = 0; k < DW/8; k++) sendByte(w[8*k +: 8], $urandom_range(maxGap, minGap));
            if (midStart && i == 0) pulseStart(b ^ 10'h2AA, 1, 2);
        end
        for (int k = 0; k < DW/8; k++) sendByte(csum[8*k +: 8], $urandom_range(maxGap, minGap));
        waitIdle(50, cyc);
        checkOutput({tag, ".writes"}, wrLog.size(), expWr.size());
        for (int i = 0; i < expWr.size() && i < wrLog.size(); i++) begin
            checkOutput({tag, ".addr"}, wrLog[i].addr, expWr[i].addr);
            checkOutput({tag, ".data"}, wrLog[i].data, expWr[i].data);
        end
        checkOutput({tag, ".done"}, doneSeen - doneBefore, expDone ? 1 : 0);
        checkOutput({tag, ".err"}, err, expDone ? 1'b0 : 1'b1);
        checkOutput({tag, ".code"}, err_code, expDone ? 2'b00 : 2'b01);
    endtask

    initial begin
        vec_t          vecs[$];
        logic [DW-1:0] words[$];
        logic [DW-1:0] csum;
        logic [DW-1:0] w0;
        int            cyc;
        int            doneBefore;

        start = 1'b0; abort = 1'b0; base_addr = '0; len = '0;
        byte_valid = 1'b0; byte_data = '0;

        vecs.push_back(vec_t'{10'h123, 1,    1'b0, 2, 1'b0});
        vecs.push_back(vec_t'{10'h3FE, 3,    1'b0, 1, 1'b0});
        vecs.push_back(vec_t'{10'h000, 5,    1'b1, 2, 1'b0});
        vecs.push_back(vec_t'{10'h200, 0,    1'b0, 1, 1'b0});
        vecs.push_back(vec_t'{10'h3FF, 1,    1'b1, 0, 1'b0});
        vecs.push_back(vec_t'{10'h040, 2,    1'b0, 1, 1'b1});
        vecs.push_back(vec_t'{10'h155, 1024, 1'b0, 1, 1'b0});

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset.busy", busy, 0);
        checkOutput("reset.cpu_hold", cpu_hold, 0);
        checkOutput("reset.byte_ready", byte_ready, 0);
        checkOutput("reset.dma_sel", dma_sel, 0);
        checkOutput("reset.dma_we", dma_we, 0);
        checkOutput("reset.dma_addr", dma_addr, 0);
        checkOutput("reset.dma_data", dma_data, 0);
        checkOutput("reset.done", done, 0);
        checkOutput("reset.err", err, 0);
        checkOutput("reset.err_code", err_code, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        words = '{32'h12345678, 32'h89ABCDEF};
        applyStimulus(10'h010, 2, words, 32'h9BE02467, 0, 0, 1'b0, "spec.good");
        applyStimulus(10'h010, 2, words, 32'h00000000, 0, 1, 1'b0, "spec.badsum");
        words.delete();
        applyStimulus(10'h010, 0, words, 32'h00000000, 0, 1, 1'b0, "spec.len0");
        words = '{$urandom(), $urandom()};
        applyStimulus(10'h3FF, 2, words, wordSum(words), 0, 1, 1'b0, "spec.wrap");

        // Stream stalls one cycle short of the timeout never trip it.
        words = '{$urandom()};
        applyStimulus(10'h0C0, 1, words, wordSum(words), IDLE_LIMIT - 1, IDLE_LIMIT - 1, 1'b0, "gap.max");

        // Mid-word stall of IDLE_LIMIT cycles times out.
        wrLog.delete();
        doneBefore = doneSeen;
        pulseStart(10'h080, 2, 1);
        sendByte(8'hA1, 0);
        sendByte(8'hB2, 0);
        waitIdle(IDLE_LIMIT + 20, cyc);
        checkOutput("timeout.cycles", cyc, IDLE_LIMIT);
        checkOutput("timeout.err", err, 1);
        checkOutput("timeout.code", err_code, 2'b10);
        checkOutput("timeout.writes", wrLog.size(), 0);
        checkOutput("timeout.done", doneSeen - doneBefore, 0);

        // Abort after five bytes: one write survives.
        wrLog.delete();
        doneBefore = doneSeen;
        w0 = $urandom();
        pulseStart(10'h020, 3, 1);
        for (int k = 0; k < 4; k++) sendByte(w0[8*k +: 8], 0);
        sendByte(8'h5A, 0);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        waitIdle(5, cyc);
        checkOutput("abort5.cycles", cyc, 0);
        checkOutput("abort5.writes", wrLog.size(), 1);
        if (wrLog.size() > 0) begin
            checkOutput("abort5.addr", wrLog[0].addr, 10'h020);
            checkOutput("abort5.data", wrLog[0].data, w0);
        end
        checkOutput("abort5.err", err, 1);
        checkOutput("abort5.code", err_code, 2'b11);
        checkOutput("abort5.done", doneSeen - doneBefore, 0);

        // Abort landing on the write cycle: the write still happens.
        wrLog.delete();
        w0 = $urandom();
        pulseStart(10'h030, 2, 1);
        for (int k = 0; k < 4; k++) sendByte(w0[8*k +: 8], 0);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        waitIdle(5, cyc);
        checkOutput("abortwr.writes", wrLog.size(), 1);
        if (wrLog.size() > 0) begin
            checkOutput("abortwr.addr", wrLog[0].addr, 10'h030);
            checkOutput("abortwr.data", wrLog[0].data, w0);
        end
        checkOutput("abortwr.code", err_code, 2'b11);

        // A following start clears the sticky error.
        doneBefore = doneSeen;
        pulseStart(10'h000, 0, 1);
        @(negedge clk);
        checkOutput("restart.busy", busy, 1);
        checkOutput("restart.err", err, 0);
        checkOutput("restart.code", err_code, 2'b00);
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) sendByte(8'h00, 0);
        waitIdle(5, cyc);
        checkOutput("restart.done", doneSeen - doneBefore, 1);

        foreach (vecs[v]) begin
            words.delete();
            for (int i = 0; i < vecs[v].n; i++) words.push_back($urandom());
            csum = wordSum(words);
            if (vecs[v].badSum) csum = csum ^ (32'h1 << $urandom_range(31, 0));
            applyStimulus(vecs[v].base, vecs[v].n, words, csum, 0, vecs[v].maxGap,
                          vecs[v].midStart, $sformatf("vec%0d", v));
        end

        for (int r = 0; r < 6; r++) begin
            int n = $urandom_range(8, 0);
            words.delete();
            for (int i = 0; i < n; i++) words.push_back($urandom());
            csum = wordSum(words);
            if ($urandom_range(1, 0) == 1) csum = csum ^ (32'h1 << $urandom_range(31, 0));
            applyStimulus(AW'($urandom()), n, words, csum, 0, 3, 1'b0, $sformatf("rand%0d", r));
        end

        // Reset mid-load: back to idle, no error, partial write kept.
        wrLog.delete();
        pulseStart(10'h100, 4, 1);
        for (int k = 0; k < 6; k++) sendByte(8'(k + 1), 0);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst.busy", busy, 0);
        checkOutput("midrst.ready", byte_ready, 0);
        checkOutput("midrst.dma_we", dma_we, 0);
        checkOutput("midrst.err", err, 0);
        checkOutput("midrst.code", err_code, 2'b00);
        checkOutput("midrst.writes", wrLog.size(), 1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        words = '{$urandom(), $urandom()};
        applyStimulus(10'h1F0, 2, words, wordSum(words), 0, 1, 1'b0, "postrst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
